// File: rtl/crc_frame_tx.sv
// Purpose : frames an 80-bit payload as a byte stream [hdr] + 10 payload bytes (MSB first) + CRC byte,
//           driving an external registered CRC unit for the CRC of the payload.
// Latency : start accepted -> first tx_valid in 3 cycles; done pulses the cycle after the last transfer.
// Backpr. : tx_valid/tx_data are registered and held stable while tx_ready is low; 1 byte/cycle when ready.
//
// Ports: clk/rst (sync, active-high); start/payload from the producer; busy status;
//        crc_en/crc_data to the CRC unit, crc_in back from it; tx_data/tx_valid/tx_ready to the
//        link; done end-of-frame pulse.
// Optional feature: define CRC_FRAME_HDR_EN to prepend HDR_BYTE (not covered by the CRC).
module crc_frame_tx #(
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] payload,
    output logic        busy,
    output logic        crc_en,
    output logic [79:0] crc_data,
    input  logic [7:0]  crc_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    localparam int PAYLOAD_BYTES = 10;
`ifdef CRC_FRAME_HDR_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
    // Header byte is not part of the frame in this build.
    logic unused_hdr;
    assign unused_hdr = ^HDR_BYTE;
`endif
    // Index of the CRC byte, which is also the final byte of the frame.
    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES + HDR_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        CAPT,
        SEND,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] crc_q;

    // Byte k of the outgoing frame.
    function automatic logic [7:0] frame_byte(input logic [3:0] k,
                                              input logic [79:0] data,
                                              input logic [7:0] crc);
        logic [79:0] sh;
        logic [3:0]  pidx;
        pidx = k - 4'(HDR_BYTES);
        sh   = data << (8 * pidx);
        frame_byte = sh[79:72];
        if (k == LAST_IDX)
            frame_byte = crc;
`ifdef CRC_FRAME_HDR_EN
        if (k == 4'd0)
            frame_byte = HDR_BYTE;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            crc_en   <= 1'b0;
            crc_data <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            crc_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        crc_data <= payload;
                        crc_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    crc_en <= 1'b0;
                    state  <= CAPT;
                end
                CAPT: begin
                    // The CRC unit registers its result, so crc_in is valid exactly here.
                    crc_q    <= crc_in;
                    cnt      <= '0;
                    tx_valid <= 1'b1;
                    tx_data  <= frame_byte(4'd0, crc_data, crc_q);
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (cnt == LAST_IDX) begin
                            tx_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt     <= cnt + 4'd1;
                            tx_data <= frame_byte(cnt + 4'd1, crc_data, crc_q);
                        end
                    end
                end
                DONE: begin
                    // busy stays high through DONE so a start here is ignored.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_tx.sv
module tb_crc_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] payload;
    logic        busy;
    logic        crc_en;
    logic [79:0] crc_data;
    logic [7:0]  crc_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crc_frame_tx dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .payload  (payload),
        .busy     (busy),
        .crc_en   (crc_en),
        .crc_data (crc_data),
        .crc_in   (crc_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done)
    );

    // x^8+1 over 80 bits with zero init reduces to the XOR of the ten bytes.
    function automatic logic [7:0] crc_ref(input logic [79:0] p);
        logic [79:0] t;
        logic [7:0]  x;
        x = 8'h00;
        for (int i = 0; i < 10; i++) begin
            t = p >> (8 * i);
            x = x ^ t[7:0];
        end
        return x;
    endfunction

    // Model of the registered CRC unit; outside its valid cycle it presents junk.
    always @(posedge clk) begin
        if (crc_en)
            crc_in <= crc_ref(crc_data);
        else
            crc_in <= 8'($urandom);
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    // mode: 0 = tx_ready always high, 1 = toggling, 2 = random.
    task automatic run_frame(input logic [79:0] pl, input int mode, input logic [7:0] crc_exp,
                             input bit mid_start, input bit start_in_done);
        logic [7:0]  q[$];
        logic [79:0] t;
        logic [7:0]  prev;
        bit          prev_stall;
        bit          finished;
        int          got;
        int          first_v;
        int          cen_cnt;
        int          cyc;
`ifdef CRC_FRAME_HDR_EN
        q.push_back(8'hA5);
`endif
        for (int k = 0; k < 10; k++) begin
            t = pl >> (8 * (9 - k));
            q.push_back(t[7:0]);
        end
        q.push_back(crc_exp);

        prev = 8'h00; prev_stall = 0; finished = 0;
        got = 0; first_v = -1; cen_cnt = 0;

        start = 1'b1; payload = pl; tx_ready = (mode == 0);
        tick();
        for (cyc = 1; cyc <= 400 && !finished; cyc++) begin
            start = 1'b0;
            payload = {$urandom, $urandom, $urandom};
            if (crc_en) begin
                cen_cnt++;
                chk("crc_data_at_en", crc_data, pl);
            end
            if (tx_valid && first_v < 0)
                first_v = cyc;
            if (prev_stall) begin
                chk("stall_valid_held", tx_valid, 1'b1);
                chk("stall_data_held", tx_data, prev);
            end
            if (got == q.size()) begin
                chk("done_pulse", done, 1'b1);
                chk("done_tx_valid", tx_valid, 1'b0);
                chk("done_busy", busy, 1'b1);
                finished = 1;
                if (start_in_done) begin
                    start = 1'b1;
                    payload = ~pl;
                end
            end else begin
                chk("no_early_done", done, 1'b0);
                chk("busy_in_frame", busy, 1'b1);
                case (mode)
                    0:       tx_ready = 1'b1;
                    1:       tx_ready = cyc[0];
                    default: tx_ready = 1'($urandom_range(0, 1));
                endcase
                if (mid_start && got >= 5 && got <= 7) begin
                    start = 1'b1;
                    payload = ~pl;
                end
                if (tx_valid && tx_ready) begin
                    chk($sformatf("byte%0d", got), tx_data, q[got]);
                    got++;
                    prev_stall = 0;
                end else begin
                    prev_stall = tx_valid;
                end
                prev = tx_data;
            end
            tick();
        end
        start = 1'b0;
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout actual=%0d_bytes expected=%0d_bytes", got, q.size());
        end
        chk("crc_en_pulses", cen_cnt, 1);
        chk("first_valid_latency", first_v, 3);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_crc_en", crc_en, 1'b0);
        chk("idle_tx_valid", tx_valid, 1'b0);
    endtask

    typedef struct {
        logic [79:0] pl;
        int          mode;
        logic [7:0]  crc;
        bit          mid_start;
        bit          start_done;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        logic [79:0] rp;
        int          got;

        vt[0] = '{80'h0,                     0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{80'h0102030405060708090A,  0, 8'h0B, 1'b0, 1'b1};
        vt[2] = '{80'h1,                     1, 8'h01, 1'b0, 1'b0};
        vt[3] = '{80'h0102030405060708090A,  0, 8'h0B, 1'b1, 1'b0};
        vt[4] = '{80'hFFEEDDCCBBAA99887766,  2, 8'h11, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; payload = '0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_crc_en", crc_en, 1'b0);
        chk("rst_crc_data", crc_data, 80'h0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        foreach (vt[i])
            run_frame(vt[i].pl, vt[i].mode, vt[i].crc, vt[i].mid_start, vt[i].start_done);

        // Reset after the fourth byte has been transferred.
        start = 1'b1; payload = 80'h0102030405060708090A; tx_ready = 1'b1;
        tick();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 50 && got < 4; c++) begin
            if (tx_valid) got++;
            tick();
        end
        chk("mid_rst_reached_byte4", got, 4);
        rst = 1'b1;
        tick();
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_crc_data", crc_data, 80'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_no_done", done, 1'b0);
        run_frame(80'h0, 0, 8'h00, 1'b0, 1'b0);

        // Randomized frames against the reference byte sequence.
        for (int n = 0; n < 20; n++) begin
            rp = {$urandom, $urandom, $urandom};
            run_frame(rp, 2, crc_ref(rp), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_frame_tx.md
Name: crc_frame_tx

Overview:
- Downstream framing stage for the 80-bit x^8+1 CRC unit (`crc_8`).
- Latches an 80-bit payload and drives the CRC unit's `crc_en`/`Data` inputs for one cycle.
- Captures the resulting 8-bit CRC and emits the frame as a byte stream over a valid/ready handshake: 10 payload bytes, MSB byte first (bits [79:72] first), then the CRC byte.
- Sits between the payload producer and the byte-oriented link transmitter.

Parameters:
- HDR_BYTE, 8'hA5, header byte sent first when CRC_FRAME_HDR_EN is defined; unused otherwise.
- The payload byte count is fixed at 10 (localparam, not overridable).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to frame `payload`; honoured only when `busy`=0
- payload  input  80  frame payload, sampled in the cycle `start` is accepted
- busy  output  1  high from the cycle after `start` is accepted until `done`
- crc_en  output  1  enable to the CRC unit; one-cycle pulse per frame
- crc_data  output  80  data to the CRC unit; holds the latched payload
- crc_in  input  8  `crc_out` returned from the CRC unit (registered there, valid one cycle after `crc_en`)
- tx_data  output  8  outgoing byte
- tx_valid  output  1  `tx_data` is valid
- tx_ready  input  1  sink accepts `tx_data`; a transfer occurs when `tx_valid`&&`tx_ready`
- done  output  1  one-cycle pulse in the cycle after the final byte is transferred

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - state=IDLE; busy=0, crc_en=0, crc_data=0, tx_data=0, tx_valid=0, done=0.
  - Byte counter=0, latched CRC=0.
- IDLE:
  - busy=0.
  - On `start`=1: latch `payload` into `crc_data` and go to CALC.
- CALC (1 cycle):
  - crc_en=1; busy=1.
  - Go to CAPT.
- CAPT (1 cycle):
  - crc_en=0.
  - Register `crc_in` into the internal CRC register; byte counter=0.
  - Go to SEND.
- SEND:
  - tx_valid=1; tx_data=byte[cnt].
  - Byte order: byte[k]=crc_data[79-8k -: 8] for k=0..9; byte[10]=latched CRC.
  - On each transfer: if cnt==10, go to DONE, else cnt+1.
  - `tx_data` holds stable while tx_valid=1 and tx_ready=0 (no retraction, no change).
  - `tx_valid` is registered; back-to-back transfers sustain 1 byte/cycle while `tx_ready`=1.
- DONE (1 cycle):
  - tx_valid=0, done=1, busy=0 in the next cycle.
  - Return to IDLE.
- Timing: minimum frame latency from `start` to first `tx_valid`=1 is 3 cycles. Minimum frame duration is 11 transfer cycles plus 4 overhead cycles.
- `start` while busy: ignored, no queuing. `payload` changes after acceptance have no effect.
- `start` in the DONE cycle: ignored. `start` is accepted the first cycle back in IDLE.
- `tx_ready` high while `tx_valid`=0: no effect.
- `rst` mid-frame: immediate return to IDLE with reset values. No `done` pulse. The partial frame is abandoned and the next frame starts cleanly.
- `crc_in` is sampled only in CAPT; other values on it are ignored.

Optional Feature:
- Macro: CRC_FRAME_HDR_EN.
- Defined:
  - SEND emits HDR_BYTE as byte 0, then the 10 payload bytes, then the CRC: 12 bytes total.
  - Counter terminates at 11.
  - HDR_BYTE is not included in the CRC.
- Undefined: 11-byte frame as above, no header logic synthesised.

Test Plan:
- Reset, then payload=80'h0, `start`, tx_ready=1:
  - 11 bytes of 8'h00 (CRC=8'h00); `done` one cycle after the last byte.
- payload=80'h0102030405060708090A, tx_ready=1:
  - Bytes 01,02,…,0A, then CRC 8'h0B; crc_en high exactly one cycle.
- payload=80'h1, tx_ready toggling 1/0 every cycle:
  - Bytes 00×9, 01, CRC 8'h01.
  - `tx_data` stable across each stall; no byte duplicated or dropped.
- Second `start` with a different payload issued mid-SEND:
  - Ignored; frame output unchanged; busy stays 1 until `done`.
- `rst` asserted after byte 4 is transferred:
  - Next cycle tx_valid=0, busy=0, no `done`.
  - A fresh 80'h0 frame then sends 11 zeros.
- CRC_FRAME_HDR_EN defined, payload=80'h0102030405060708090A:
  - Bytes A5, 01…0A, 0B (12 transfers).
